config_frame_bank: RTL and testbench
====================================

# config_frame_bank

Parametrised configuration-memory bank: an array of `NUM_WORDS` words of `DATA_WIDTH` configuration bits, each driving `Q`/`Qb` into the fabric. It generalises the single-bit word-line/bit-line cell with three additions. A serial frame loader auto-increments the address. A direct parallel word write is addressed by word line. A serial readback path returns stored data. It sits between the bitstream loader and the routing/LUT configuration inputs.

## Interface
- `DATA_WIDTH`, 8, bits per configuration word (≥1)
- `NUM_WORDS`, 16, words in the bank (≥2)
- `ADDR_WIDTH`, `$clog2(NUM_WORDS)`, word-address width

- `prog_clk`  in  1  configuration clock; all state changes on its rising edge
- `resetb`  in  1  reset, synchronous, active-low
- `load_start`  in  1  begin serial frame load at word 0
- `bit_in`  in  1  serial configuration bit, LSB of each word first
- `bit_valid`  in  1  `bit_in` qualifier
- `wl_en`  in  1  direct word write strobe
- `wl_addr`  in  ADDR_WIDTH  direct write word address
- `bl`  in  DATA_WIDTH  direct write data
- `rb_start`  in  1  begin readback of word `rb_addr`
- `rb_addr`  in  ADDR_WIDTH  readback word address
- `rb_bit`  out  1  readback bit, LSB first
- `rb_valid`  out  1  `rb_bit` qualifier
- `Q`  out  NUM_WORDS*DATA_WIDTH  stored bits; word k occupies `[k*DATA_WIDTH +: DATA_WIDTH]`
- `Qb`  out  NUM_WORDS*DATA_WIDTH  bitwise complement of `Q`
- `busy`  out  1  high in SHIFT or READBACK
- `done`  out  1  full frame loaded; level signal
- `err`  out  1  sticky protocol error

## Operation
- **Reset (`resetb`=0 at edge):**
  - All words become 0, so `Q`=0 and `Qb`=all ones.
  - `busy`, `done`, `err`, `rb_bit` and `rb_valid` become 0.
  - FSM goes to IDLE. Reset overrides every other input, including mid-load and mid-readback.
- **FSM states:** IDLE, SHIFT, READBACK.
- **IDLE, request priority:** `load_start` > `wl_en` > `rb_start`. A lower-priority request that arrives in the same cycle as a higher one is dropped and sets `err`.
- **Starting a load:**
  - `load_start` moves the FSM to SHIFT.
  - Word pointer = 0, bit count = 0, `done` = 0, `err` = 0.
- **SHIFT:**
  - Each cycle with `bit_valid`=1, `bit_in` shifts into the word assembly register at bit position `bit count`.
  - On the `DATA_WIDTH`-th valid bit, the assembled word (including that bit) is written to word[pointer] on the same edge.
  - If the pointer equals `NUM_WORDS`-1: set `done`, go to IDLE. Otherwise: pointer+1, bit count = 0.
  - `bit_valid`=0 stalls with no timeout.
  - `load_start` in SHIFT restarts at word 0 and clears `err`. Words already written are kept until overwritten.
  - `wl_en` or `rb_start` in SHIFT is ignored and sets `err`.
- **Direct write (IDLE only):**
  - `wl_en`=1 writes word[`wl_addr`] <= `bl`.
  - If `wl_addr` ≥ `NUM_WORDS`, nothing is written and `err` is set.
  - `done` is unchanged.
- **READBACK:**
  - `rb_start` in IDLE latches word[`rb_addr`] into an output shift register.
  - Over the following `DATA_WIDTH` cycles, `rb_valid`=1 and `rb_bit` = bits 0..`DATA_WIDTH`-1 in order. The FSM then returns to IDLE.
  - If `rb_addr` ≥ `NUM_WORDS`, the request is rejected, `err` is set and the FSM stays in IDLE.
  - `load_start` during READBACK aborts the readback (`rb_valid` drops next cycle) and starts a load.
  - `wl_en` during READBACK is ignored and sets `err`.
- **`err`:** sticky; cleared only by reset or an accepted `load_start`.
- **Formal mode:** under `ENABLE_FORMAL_VERIFICATION`, `Q` is driven Z and `Qb` = `!Q`.

## Timing
- **Direct write:** visible on `Q`/`Qb` the cycle after the `wl_en` edge (1-cycle latency).
- **Serial load:**
  - Word k is visible the cycle after its `DATA_WIDTH`-th valid bit.
  - A minimum full load takes 1 + `NUM_WORDS`×`DATA_WIDTH` cycles.
  - `done` rises with the last word's write edge.
- **Readback:**
  - First `rb_valid` occurs the cycle after `rb_start` is accepted.
  - `rb_valid` is high for exactly `DATA_WIDTH` consecutive cycles.
  - `busy` falls together with the last `rb_valid`.
- **Outputs:** all are registered; there is no combinational input-to-output path.

## Structure
- **Package `config_frame_bank_pkg`:**
  - state enum `cfb_state_t` (IDLE/SHIFT/READBACK)
  - helper function for the word slice offset
- **Sub-module `config_word_latch`:**
  - one `DATA_WIDTH` storage word with synchronous active-low reset, write enable and data; drives its `Q`/`Qb` slice
  - instantiated `NUM_WORDS` times via generate
  - the write enable is the OR of the serial commit and the direct-write decode for that word

## Test plan
- **Reset values:** with `DATA_WIDTH`=8, `NUM_WORDS`=4, hold `resetb`=0 for 2 cycles → `Q`=0, `Qb`=32'hFFFFFFFF, `busy`/`done`/`err`=0.
- **Serial load with stalls:** shift 32 bits encoding words 8'hA5, 8'h3C, 8'hFF, 8'h01 (LSB first), with `bit_valid` gaps → `Q`=32'h01FF3CA5. `done` rises on the 32nd valid bit's edge.
- **Direct write:** `wl_en` with `wl_addr`=2, `bl`=8'h5A → the next cycle `Q[23:16]`=8'h5A, other words unchanged, `err`=0.
- **Readback:** `rb_start`, `rb_addr`=0, after the above load → `rb_valid` high for 8 cycles, `rb_bit` sequence 1,0,1,0,0,1,0,1.
- **Collisions:** `load_start` and `wl_en` in the same cycle → load proceeds, no write occurs, `err`=1. A later `load_start` → `err`=0.
- **Reset mid-load:** assert `resetb`=0 after 12 valid bits → `Q`=0 and FSM IDLE the next cycle. A subsequent `bit_valid` without `load_start` has no effect.

Source files
------------

// File: rtl/config_frame_bank_pkg.sv
// Shared types and helpers for the configuration frame bank.
package config_frame_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_READBACK = 2'd2
  } cfb_state_t;

  // Bit offset of word k inside the flattened Q/Qb buses.
  function automatic int word_offset(input int k, input int data_width);
    return k * data_width;
  endfunction

endpackage

// File: rtl/config_word_latch.sv
// One configuration word: synchronously reset storage driving its Q/Qb slice.
module config_word_latch #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic [DATA_WIDTH-1:0] q_o,
  output logic [DATA_WIDTH-1:0] qb_o
);

  logic [DATA_WIDTH-1:0] word_q;

  // NOTE: configuration storage is reset on purpose so the fabric never sees
  // random routing before a bitstream arrives.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)  word_q <= '0;
    else if (we_i) word_q <= d_i;
  end

  assign word_o = word_q;

`ifdef ENABLE_FORMAL_VERIFICATION
  assign q_o = 'z;
`else
  assign q_o = word_q;
`endif
  assign qb_o = ~q_o;

endmodule

// File: rtl/config_frame_bank.sv
// Configuration memory bank with serial frame load, direct word write and
// serial readback, all clocked by prog_clk.
module config_frame_bank
  import config_frame_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                            prog_clk,
  input  logic                            resetb,
  input  logic                            load_start,
  input  logic                            bit_in,
  input  logic                            bit_valid,
  input  logic                            wl_en,
  input  logic [ADDR_WIDTH-1:0]           wl_addr,
  input  logic [DATA_WIDTH-1:0]           bl,
  input  logic                            rb_start,
  input  logic [ADDR_WIDTH-1:0]           rb_addr,
  output logic                            rb_bit,
  output logic                            rb_valid,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] Q,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] Qb,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

  cfb_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [DATA_WIDTH-1:0] rb_sr_q, rb_sr_d;
  logic [CNT_W-1:0]      rb_cnt_q, rb_cnt_d;
  logic                  rb_bit_q, rb_bit_d;
  logic                  rb_valid_q, rb_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  commit, direct_we;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] word_q [NUM_WORDS];

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return int'(a) < NUM_WORDS;
  endfunction

  // NOTE: every variable gets its default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    bitcnt_d   = bitcnt_q;
    asm_d      = asm_q;
    rb_sr_d    = rb_sr_q;
    rb_cnt_d   = rb_cnt_q;
    rb_bit_d   = rb_bit_q;
    rb_valid_d = rb_valid_q;
    done_d     = done_q;
    err_d      = err_q;
    commit     = 1'b0;
    direct_we  = 1'b0;

    if (load_start) begin
      // An accepted load clears err; a colliding request re-sets it below.
      state_d    = ST_SHIFT;
      ptr_d      = '0;
      bitcnt_d   = '0;
      asm_d      = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      rb_valid_d = 1'b0;
      if (wl_en || (rb_start && state_q != ST_READBACK)) err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wl_en) begin
            if (addr_ok(wl_addr)) direct_we = 1'b1;
            else                  err_d     = 1'b1;
            if (rb_start) err_d = 1'b1;
          end else if (rb_start) begin
            if (addr_ok(rb_addr)) begin
              state_d    = ST_READBACK;
              rb_bit_d   = word_q[rb_addr][0];
              rb_sr_d    = word_q[rb_addr] >> 1;
              rb_cnt_d   = '0;
              rb_valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (wl_en || rb_start) err_d = 1'b1;
          if (bit_valid) begin
            asm_d[bitcnt_q] = bit_in;
            if (bitcnt_q == LAST_BIT) begin
              commit   = 1'b1;
              bitcnt_d = '0;
              if (ptr_q == LAST_WORD) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end else begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
              end
            end else begin
              bitcnt_d = bitcnt_q + CNT_W'(1);
            end
          end
        end
        ST_READBACK: begin
          if (wl_en) err_d = 1'b1;
          if (rb_cnt_q == LAST_BIT) begin
            rb_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            rb_bit_d = rb_sr_q[0];
            rb_sr_d  = rb_sr_q >> 1;
            rb_cnt_d = rb_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge prog_clk) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      bitcnt_q   <= '0;
      asm_q      <= '0;
      rb_sr_q    <= '0;
      rb_cnt_q   <= '0;
      rb_bit_q   <= 1'b0;
      rb_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      bitcnt_q   <= bitcnt_d;
      asm_q      <= asm_d;
      rb_sr_q    <= rb_sr_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_bit_q   <= rb_bit_d;
      rb_valid_q <= rb_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Serial commit and direct write never coincide, so one data bus serves both.
  assign wr_data = commit ? asm_d : bl;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    localparam int OFS = word_offset(k, DATA_WIDTH);
    logic we;
    assign we = (commit && ptr_q == ADDR_WIDTH'(k)) ||
                (direct_we && wl_addr == ADDR_WIDTH'(k));

    config_word_latch #(.DATA_WIDTH(DATA_WIDTH)) u_word (
      .clk_i   (prog_clk),
      .rst_n_i (resetb),
      .we_i    (we),
      .d_i     (wr_data),
      .word_o  (word_q[k]),
      .q_o     (Q[OFS +: DATA_WIDTH]),
      .qb_o    (Qb[OFS +: DATA_WIDTH])
    );
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign rb_bit   = rb_bit_q;
  assign rb_valid = rb_valid_q;

endmodule

// File: tb/tb_config_frame_bank.sv
// Directed bench for config_frame_bank with a readback scoreboard.
module tb_config_frame_bank;

  localparam int DW = 8;
  localparam int NW = 4;
  localparam int AW = 2;

  logic          prog_clk = 1'b0;
  logic          resetb, load_start, bit_in, bit_valid, wl_en, rb_start;
  logic [AW-1:0] wl_addr, rb_addr;
  logic [DW-1:0] bl;
  logic          rb_bit, rb_valid, busy, done, err;
  logic [NW*DW-1:0] Q, Qb;

  int n_tests = 0;
  int n_fail  = 0;

  logic exp_q [$];
  int   rb_run = 0;
  int   last_run = 0;

  always #5 prog_clk = ~prog_clk;

  config_frame_bank #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .ADDR_WIDTH(AW)) dut (
    .prog_clk   (prog_clk),
    .resetb     (resetb),
    .load_start (load_start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .wl_en      (wl_en),
    .wl_addr    (wl_addr),
    .bl         (bl),
    .rb_start   (rb_start),
    .rb_addr    (rb_addr),
    .rb_bit     (rb_bit),
    .rb_valid   (rb_valid),
    .Q          (Q),
    .Qb         (Qb),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    for (int b = 0; b < DW; b++) exp_q.push_back(w[b]);
  endtask

  task automatic wait_readback(input string name);
    int budget = 30;
    while ((busy || exp_q.size() != 0) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check({name, "_timeout"}, 64'd0, 64'd1);
    tick();
    check({name, "_len"}, 64'(last_run), 64'(DW));
    check({name, "_valid_low"}, 64'(rb_valid), 64'd0);
  endtask

  // Monitor: pops one expected bit per rb_valid cycle.
  always @(negedge prog_clk) begin
    if (rb_valid) begin
      rb_run++;
      if (exp_q.size() == 0) begin
        check("rb_unexpected", 64'(rb_bit), 64'hx);
      end else begin
        check("rb_bit", 64'(rb_bit), 64'(exp_q.pop_front()));
      end
    end else if (rb_run != 0) begin
      last_run = rb_run;
      rb_run   = 0;
    end
  end

  initial begin
    logic [NW*DW-1:0] frame;
    frame      = 32'h01FF3CA5;
    resetb     = 1'b0;
    load_start = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    wl_en      = 1'b0;
    wl_addr    = '0;
    bl         = '0;
    rb_start   = 1'b0;
    rb_addr    = '0;
    tick();
    tick();
    check("rst_Q",    64'(Q),    64'h0);
    check("rst_Qb",   64'(Qb),   64'hFFFFFFFF);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err",  64'(err),  64'd0);
    check("rst_rbv",  64'(rb_valid), 64'd0);
    resetb = 1'b1;

    // Serial load with bit_valid gaps.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("load_busy", 64'(busy), 64'd1);
    check("load_done0", 64'(done), 64'd0);
    for (int i = 0; i < NW * DW; i++) begin
      if (i % 5 == 2) begin
        bit_valid = 1'b0;
        bit_in    = ~frame[i];
        tick();
      end
      if (i == NW * DW - 1) check("done_before_last", 64'(done), 64'd0);
      bit_valid = 1'b1;
      bit_in    = frame[i];
      tick();
      if (i == DW - 1) check("word0_early", 64'(Q), 64'h000000A5);
    end
    bit_valid = 1'b0;
    check("load_Q",    64'(Q),    64'h01FF3CA5);
    check("load_Qb",   64'(Qb),   64'hFE00C35A);
    check("load_done", 64'(done), 64'd1);
    check("load_idle", 64'(busy), 64'd0);

    // Direct write.
    wl_en   = 1'b1;
    wl_addr = 2'd2;
    bl      = 8'h5A;
    tick();
    wl_en = 1'b0;
    check("dw_Q",    64'(Q),    64'h015A3CA5);
    check("dw_err",  64'(err),  64'd0);
    check("dw_done", 64'(done), 64'd1);

    // Readback of word 0 then word 2.
    push_word(8'hA5);
    rb_start = 1'b1;
    rb_addr  = 2'd0;
    tick();
    rb_start = 1'b0;
    check("rb0_busy", 64'(busy), 64'd1);
    wait_readback("rb0");
    push_word(8'h5A);
    rb_start = 1'b1;
    rb_addr  = 2'd2;
    tick();
    rb_start = 1'b0;
    wait_readback("rb2");

    // Collision: load wins, write dropped, err set.
    load_start = 1'b1;
    wl_en      = 1'b1;
    wl_addr    = 2'd1;
    bl         = 8'h77;
    tick();
    load_start = 1'b0;
    wl_en      = 1'b0;
    check("col_err",  64'(err),  64'd1);
    check("col_busy", 64'(busy), 64'd1);
    check("col_done", 64'(done), 64'd0);
    check("col_Q",    64'(Q),    64'h015A3CA5);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("reload_err", 64'(err), 64'd0);
    wl_en = 1'b1;
    tick();
    wl_en = 1'b0;
    check("shift_wl_err", 64'(err), 64'd1);
    check("shift_wl_Q",   64'(Q),   64'h015A3CA5);

    // Reset after 12 valid bits.
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == DW - 1) check("partial_Q", 64'(Q), 64'h015A3CFF);
    end
    bit_valid = 1'b0;
    resetb    = 1'b0;
    tick();
    resetb = 1'b1;
    check("midrst_Q",    64'(Q),    64'h0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_err",  64'(err),  64'd0);
    bit_valid = 1'b1;
    repeat (DW) tick();
    bit_valid = 1'b0;
    tick();
    check("noload_Q",    64'(Q),    64'h0);
    check("noload_busy", 64'(busy), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
